// File: rtl/sort_restore.sv
// sort_restore: inverse of the 3-input ascending sorter.
// Takes a sorted triple (s0<=s1<=s2) plus the permutation that produced it,
// rebuilds the original A/B/C order and streams it out one element per beat.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      upstream handshake
//   in_s0..in_s2           sorted elements (smallest first)
//   in_perm                {p2,p1,p0}; p_k is the original slot of s_k (0=A,1=B,2=C)
//   out_valid/out_ready    downstream handshake, one beat per element
//   out_data/out_idx       restored element and its slot
//   out_last               marks the slot-C beat
//   err_perm               one-cycle pulse: invalid permutation dropped
//   err_order              one-cycle pulse: unsorted triple dropped
//   err_cnt                saturating count of dropped transactions
//
// Optional feature: define SORT_RESTORE_ORDER_CHECK_EN to also drop
// transactions whose s values are not ascending (unsigned).
module sort_restore #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_s0,
    input  logic [WIDTH-1:0]     in_s1,
    input  logic [WIDTH-1:0]     in_s2,
    input  logic [5:0]           in_perm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [1:0]           out_idx,
    output logic                 out_last,
    output logic                 err_perm,
    output logic                 err_order,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, EMIT_A, EMIT_B, EMIT_C} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     data_q [3];
    logic [WIDTH-1:0]     data_d [3];

    logic                 out_valid_d, out_last_d, err_perm_d, err_order_d;
    logic [WIDTH-1:0]     out_data_d;
    logic [1:0]           out_idx_d;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    logic [1:0] p0, p1, p2;
    logic       perm_ok, order_ok, accept, keep;

    assign p0 = in_perm[1:0];
    assign p1 = in_perm[3:2];
    assign p2 = in_perm[5:4];

    // Legal permutation: every slot in range and no two elements sharing a slot.
    assign perm_ok = (p0 != 2'd3) && (p1 != 2'd3) && (p2 != 2'd3) &&
                     (p0 != p1) && (p0 != p2) && (p1 != p2);

`ifdef SORT_RESTORE_ORDER_CHECK_EN
    assign order_ok = (in_s0 <= in_s1) && (in_s1 <= in_s2);
`else
    assign order_ok = 1'b1;
`endif

    // Combinational so a new transaction can enter as the last beat leaves.
    assign in_ready = !rst && ((state_q == IDLE) || ((state_q == EMIT_C) && out_ready));
    assign accept   = in_valid && in_ready;
    assign keep     = accept && perm_ok && order_ok;

    // Next state, buffer and registered-output values.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_idx_d   = 2'd0;
        out_last_d  = 1'b0;
        err_perm_d  = accept && !perm_ok;
        err_order_d = accept && !order_ok;
        err_cnt_d   = err_cnt;

        if (accept && !(perm_ok && order_ok) && (err_cnt != '1)) begin
            err_cnt_d = ERR_CNT_W'(err_cnt + 1'b1);
        end

        // Scatter sorted elements back to their original slots.
        if (keep) begin
            data_d[p0] = in_s0;
            data_d[p1] = in_s1;
            data_d[p2] = in_s2;
        end

        case (state_q)
            IDLE:    if (keep) state_d = EMIT_A;
            EMIT_A:  if (out_ready) state_d = EMIT_B;
            EMIT_B:  if (out_ready) state_d = EMIT_C;
            EMIT_C:  if (out_ready) state_d = keep ? EMIT_A : IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs follow the state being entered; buffer is only rewritten on
        // accept, so a stalled beat stays stable.
        case (state_d)
            EMIT_A: begin
                out_valid_d = 1'b1;
                out_idx_d   = 2'd0;
                out_data_d  = data_d[0];
            end
            EMIT_B: begin
                out_valid_d = 1'b1;
                out_idx_d   = 2'd1;
                out_data_d  = data_d[1];
            end
            EMIT_C: begin
                out_valid_d = 1'b1;
                out_idx_d   = 2'd2;
                out_data_d  = data_d[2];
                out_last_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // State, buffer and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '{default: '0};
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= 2'd0;
            out_last  <= 1'b0;
            err_perm  <= 1'b0;
            err_order <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_idx   <= out_idx_d;
            out_last  <= out_last_d;
            err_perm  <= err_perm_d;
            err_order <= err_order_d;
            err_cnt   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_sort_restore.sv
// Self-checking bench for sort_restore: directed scenarios plus a randomized
// run against a beat-queue reference model.
module tb_sort_restore;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 8;
    localparam logic [5:0]  IDENT = 6'b10_01_00;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_s0, in_s1, in_s2;
    logic [5:0]    in_perm;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    out_idx;
    logic          out_last;
    logic          err_perm;
    logic          err_order;
    logic [CW-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   i;
    } beat_t;

    sort_restore #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2), .in_perm(in_perm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .err_perm(err_perm), .err_order(err_order), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // A permutation is legal when it maps the three elements onto {A,B,C}.
    function automatic bit ref_perm_ok(input logic [5:0] pm);
        bit seen [3];
        int v;
        seen = '{default: 1'b0};
        for (int k = 0; k < 3; k++) begin
            v = int'(pm[2*k +: 2]);
            if (v > 2) return 1'b0;
            if (seen[v]) return 1'b0;
            seen[v] = 1'b1;
        end
        return 1'b1;
    endfunction

    task automatic start_txn(input int a, input int b, input int c, input logic [5:0] pm);
        in_valid = 1'b1;
        in_s0    = W'(a);
        in_s1    = W'(b);
        in_s2    = W'(c);
        in_perm  = pm;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_s0 = 8'd1; in_s1 = 8'd2; in_s2 = 8'd3; in_perm = IDENT;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== 2'd0 || out_last !== 1'b0 ||
            err_perm !== 1'b0 || err_order !== 1'b0 || err_cnt !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%0d idx=%0d last=%b ep=%b eo=%b cnt=%0d rdy=%b, want all 0",
                     out_valid, out_data, out_idx, out_last, err_perm, err_order, err_cnt, in_ready);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [W-1:0] exp_d [3];
        exp_d = '{8'd7, 8'd9, 8'd3};
        out_ready = 1'b1;
        start_txn(3, 7, 9, {2'd1, 2'd0, 2'd2});
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_idx !== 2'(i) || out_last !== (i == 2)) begin
                errors++;
                $display("FAIL basic_beat%0d: valid=%b data=%0d idx=%0d last=%b want 1/%0d/%0d/%0d",
                         i, out_valid, out_data, out_idx, out_last, exp_d[i], i, (i == 2));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        start_txn(3, 7, 9, {2'd1, 2'd0, 2'd2});
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd7 || out_idx !== 2'd0) begin
            errors++;
            $display("FAIL bp_beatA: data=%0d idx=%0d want 7/0", out_data, out_idx);
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'd9 || out_idx !== 2'd1 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b data=%0d idx=%0d last=%b want 1/9/1/0",
                         i, out_valid, out_data, out_idx, out_last);
            end
            if (i == 4) out_ready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd3 || out_idx !== 2'd2 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL bp_beatC: valid=%b data=%0d idx=%0d last=%b want 1/3/2/1",
                     out_valid, out_data, out_idx, out_last);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_d [6];
        exp_d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        out_ready = 1'b1;
        start_txn(1, 2, 3, IDENT);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_idx !== 2'(i % 3) || out_last !== (i % 3 == 2)) begin
                errors++;
                $display("FAIL b2b_beat%0d: valid=%b data=%0d idx=%0d last=%b want 1/%0d/%0d/%0d",
                         i, out_valid, out_data, out_idx, out_last, exp_d[i], i % 3, (i % 3 == 2));
            end
            if (i == 2) begin
                start_txn(4, 5, 6, IDENT);
                #1;
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready_in_C: got %b want 1", in_ready);
                end
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_invalid_perm();
        logic [5:0] pm;
        bit         saw_valid;
        do_reset();
        start_txn(1, 2, 3, {2'd1, 2'd0, 2'd0});
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (err_perm !== 1'b1 || err_cnt !== 8'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL inv_first: ep=%b cnt=%0d valid=%b want 1/1/0", err_perm, err_cnt, out_valid);
        end
        @(negedge clk);
        checks++;
        if (err_perm !== 1'b0 || err_cnt !== 8'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL inv_pulse_end: ep=%b cnt=%0d valid=%b want 0/1/0", err_perm, err_cnt, out_valid);
        end
        saw_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            do pm = 6'($urandom()); while (ref_perm_ok(pm));
            start_txn(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), pm);
            @(negedge clk);
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err_cnt !== 8'd255 || saw_valid || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL inv_saturate: cnt=%0d saw_valid=%b want 255/0", err_cnt, saw_valid);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        start_txn(10, 20, 30, IDENT);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 2'd1 || out_data !== 8'd20) begin
            errors++;
            $display("FAIL mid_in_B: valid=%b idx=%0d data=%0d want 1/1/20", out_valid, out_idx, out_data);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || err_cnt !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b cnt=%0d rdy=%b want 0/0/0", out_valid, err_cnt, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: rdy=%b valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_order();
        do_reset();
        start_txn(9, 3, 7, IDENT);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef SORT_RESTORE_ORDER_CHECK_EN
        checks++;
        if (err_order !== 1'b1 || err_perm !== 1'b0 || err_cnt !== 8'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL order_drop: eo=%b ep=%b cnt=%0d valid=%b want 1/0/1/0",
                     err_order, err_perm, err_cnt, out_valid);
        end
`else
        begin
            logic [W-1:0] exp_d [3];
            exp_d = '{8'd9, 8'd3, 8'd7};
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_idx !== 2'(i) ||
                    err_order !== 1'b0 || err_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL order_pass%0d: valid=%b data=%0d idx=%0d eo=%b cnt=%0d want 1/%0d/%0d/0/0",
                             i, out_valid, out_data, out_idx, err_order, err_cnt, exp_d[i], i);
                end
                @(negedge clk);
            end
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_random();
        beat_t        q [$];
        beat_t        b;
        logic [W-1:0] s [3];
        logic [W-1:0] r [3];
        logic [W-1:0] t;
        logic [5:0]   pm;
        bit           pend_p, pend_o, exp_ready, pok, ook;
        int unsigned  cnt;
        int unsigned  hi;
        do_reset();
        pend_p = 1'b0; pend_o = 1'b0; cnt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            checks++;
            if (out_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rnd_valid c%0d: got %b want %0d", cyc, out_valid, (q.size() != 0));
            end else if (q.size() != 0) begin
                checks++;
                if (out_data !== q[0].d || out_idx !== q[0].i || out_last !== (q[0].i == 2'd2)) begin
                    errors++;
                    $display("FAIL rnd_beat c%0d: data=%0d idx=%0d last=%b want %0d/%0d/%0d",
                             cyc, out_data, out_idx, out_last, q[0].d, q[0].i, (q[0].i == 2'd2));
                end
            end
            checks++;
            if (err_perm !== pend_p || err_order !== pend_o || err_cnt !== CW'(cnt)) begin
                errors++;
                $display("FAIL rnd_err c%0d: ep=%b eo=%b cnt=%0d want %0d/%0d/%0d",
                         cyc, err_perm, err_order, err_cnt, pend_p, pend_o, cnt);
            end

            hi = ($urandom_range(0, 1) != 0) ? 255 : 7;
            for (int k = 0; k < 3; k++) s[k] = W'($urandom_range(0, hi));
            if ($urandom_range(0, 3) != 0) begin
                for (int a = 0; a < 2; a++)
                    for (int k = 0; k < 2 - a; k++)
                        if (s[k] > s[k+1]) begin t = s[k]; s[k] = s[k+1]; s[k+1] = t; end
            end
            if ($urandom_range(0, 4) != 0) begin
                do pm = 6'($urandom()); while (!ref_perm_ok(pm));
            end else begin
                pm = 6'($urandom());
            end
            if (cyc < 560) begin
                out_ready = ($urandom_range(0, 3) != 0);
                in_valid  = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
            in_s0 = s[0]; in_s1 = s[1]; in_s2 = s[2]; in_perm = pm;
            #1;
            exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL rnd_ready c%0d: got %b want %0d", cyc, in_ready, exp_ready);
            end
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            pend_p = 1'b0; pend_o = 1'b0;
            if (in_valid && exp_ready) begin
                pok = ref_perm_ok(pm);
                ook = 1'b1;
`ifdef SORT_RESTORE_ORDER_CHECK_EN
                ook = (s[0] <= s[1]) && (s[1] <= s[2]);
`endif
                pend_p = !pok;
                pend_o = !ook;
                if (pok && ook) begin
                    r[pm[1:0]] = s[0];
                    r[pm[3:2]] = s[1];
                    r[pm[5:4]] = s[2];
                    for (int k = 0; k < 3; k++) begin
                        b.d = r[k];
                        b.i = 2'(k);
                        q.push_back(b);
                    end
                end else if (cnt < 255) begin
                    cnt++;
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_s0 = '0; in_s1 = '0; in_s2 = '0; in_perm = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_invalid_perm();
        test_reset_midstream();
        test_order();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_restore.md
Name: sort_restore

Overview:
- Inverse of the team's 3-input ascending sorter.
- Takes a sorted triple plus the permutation that produced it, and rebuilds the original A/B/C order.
- Streams the restored triple out serially, one element per beat, over a valid/ready handshake.
- Sits downstream of sort-based processing (ranking, median, min/max stages) so results can be returned in original lane order.

Parameters:
- WIDTH, 8, bit width of each element.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  upstream transaction valid.
- in_ready  output  1  block can accept a transaction this cycle.
- in_s0  input  WIDTH  smallest sorted element.
- in_s1  input  WIDTH  middle sorted element.
- in_s2  input  WIDTH  largest sorted element.
- in_perm  input  6  {p2,p1,p0}; p_k (2 bits) is the original slot of s_k: 0=A, 1=B, 2=C.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  restored element.
- out_idx  output  2  slot of current beat: 0=A, 1=B, 2=C.
- out_last  output  1  high on the slot-C beat.
- err_perm  output  1  one-cycle pulse: invalid permutation dropped.
- err_order  output  1  one-cycle pulse: order violation dropped (macro only).
- err_cnt  output  ERR_CNT_W  saturating count of dropped transactions.

Behaviour:
- Reset (synchronous, active-high, has priority over all other logic):
  - state=IDLE; out_valid, out_data, out_idx, out_last, err_perm, err_order, err_cnt all 0; in_ready=0 while rst is high.
  - First cycle after rst deasserts: in_ready=1.
- Accept: in_valid && in_ready at a rising edge.
- Buffer update on accept: buf[p_k] <= s_k for k=0..2.
- Permutation validity:
  - p0, p1, p2 each < 3 and pairwise distinct.
  - Six legal codes; anything else is invalid.
- States: IDLE, EMIT_A, EMIT_B, EMIT_C.
  - IDLE: in_ready=1, out_valid=0. Valid accept -> EMIT_A. Invalid accept -> stay IDLE, no beats.
  - EMIT_A / EMIT_B: out_valid=1, out_data=buf[0] / buf[1], out_idx=0 / 1. Advance on out_ready.
  - EMIT_C: out_valid=1, out_data=buf[2], out_idx=2, out_last=1. in_ready = out_ready, so a new transaction is accepted in the same cycle the last beat leaves.
  - EMIT_C on out_ready: new valid accept -> EMIT_A (zero bubble); otherwise -> IDLE.
- Latency: accept at edge T; first beat presented in the cycle after T. Peak throughput is one transaction per 3 cycles.
- Backpressure: while out_valid && !out_ready, out_data, out_idx and out_last hold stable. No beat is skipped or duplicated.
- Error handling:
  - An invalid transaction is consumed and dropped; the buffer is left unchanged.
  - err_perm pulses high for the one cycle after the accepting edge.
  - err_cnt increments by 1 per dropped transaction and saturates at 2^ERR_CNT_W-1. Only reset clears it.
- Ties: equal s values are legal. Output is still driven purely by in_perm.
- Comparisons are unsigned.
- Reset mid-stream: any in-flight transaction is discarded with no further beats. Next cycle out_valid=0, state=IDLE.
- in_* inputs are ignored whenever in_ready=0.

Optional Feature:
- Macro: SORT_RESTORE_ORDER_CHECK_EN.
- When defined:
  - Each accepted transaction with a valid perm is also checked for in_s0 <= in_s1 <= in_s2 (unsigned).
  - On violation: transaction dropped, err_order pulses one cycle after accept, err_cnt increments.
  - If the perm is also invalid: err_perm and err_order both pulse, and err_cnt increments once.
- When undefined: no order check; err_order tied to 0; unsorted input is restored and emitted as-is.

Test Plan:
1. s=(3,7,9), perm p0=2, p1=0, p2=1, out_ready=1 -> beats A=7, B=9, C=3 on three consecutive cycles starting the cycle after accept; out_last only on C.
2. Same stimulus, out_ready low for 4 cycles during the B beat -> out_data=9, out_idx=1 held all 4 cycles; C=3 follows one cycle after out_ready returns.
3. Two back-to-back transactions, identity perm (0,1,2), s=(1,2,3) then (4,5,6), out_ready=1 -> 6 beats 1,2,3,4,5,6 in 6 consecutive cycles; in_ready high during EMIT_C.
4. perm p0=0, p1=0, p2=1 -> no beats, err_perm pulse, err_cnt=1. Drive 300 invalid perms -> err_cnt=255 (saturated).
5. rst asserted while in EMIT_B -> next cycle out_valid=0, err_cnt=0; in_ready=1 the cycle after rst deasserts.
6. s=(9,3,7), identity perm:
   - macro defined -> dropped, err_order pulse, err_cnt=1.
   - macro undefined -> beats 9, 3, 7.
